// File: rtl/uart_fifo.sv
// 16x8 first-word-fall-through FIFO for the 16550A transmit/receive paths.
// Provides empty/full/trigger status and one-cycle overrun/underrun pulses.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             push_in,
  input  logic             pop_in,
  input  logic [WIDTH-1:0] din,
  input  logic [3:0]       thres,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic             underrun,
  output logic             overrun,
  output logic             thres_tri
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             r_overrun;
  logic             r_underrun;

  logic w_push;
  logic w_pop;
  logic w_empty;
  logic w_full;
  logic w_doWrite;
  logic w_doRead;

  assign w_push  = en & push_in;
  assign w_pop   = en & pop_in;
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));

  // A pop at full frees the slot the simultaneous push lands in.
  assign w_doWrite = w_push & (~w_full | w_pop);
  assign w_doRead  = w_pop & ~w_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overrun  <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      if (w_doWrite) begin
        r_mem[r_wptr] <= din;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_doRead) begin
        r_rptr <= r_rptr + AW'(1);
      end
      r_count    <= r_count + CW'(w_doWrite) - CW'(w_doRead);
      r_overrun  <= w_push & w_full & ~w_pop;
      r_underrun <= w_pop & w_empty;
    end
  end

  assign empty     = w_empty;
  assign full      = w_full;
  assign overrun   = r_overrun;
  assign underrun  = r_underrun;
  assign thres_tri = (32'(r_count) >= 32'(thres));
  assign dout      = w_empty ? '0 : r_mem[r_rptr];

endmodule

// File: tb/tb_uart_fifo.sv
// Self-checking bench for uart_fifo: directed vector table, test-plan sequences
// and a randomized run, all checked against a queue-based reference model.
module tb_uart_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       push_in = 1'b0;
  logic       pop_in = 1'b0;
  logic [7:0] din = 8'h00;
  logic [3:0] thres = 4'd0;
  logic [7:0] dout;
  logic       empty;
  logic       full;
  logic       underrun;
  logic       overrun;
  logic       thres_tri;

  uart_fifo #(.WIDTH(8), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .en(en), .push_in(push_in), .pop_in(pop_in),
    .din(din), .thres(thres), .dout(dout), .empty(empty), .full(full),
    .underrun(underrun), .overrun(overrun), .thres_tri(thres_tri)
  );

  always #5 clk = ~clk;

  logic [7:0] model[$];
  bit         expOver;
  bit         expUnder;
  int         total = 0;
  int         bad = 0;

  typedef struct {
    bit         e;
    bit         p;
    bit         o;
    logic [7:0] d;
    logic [3:0] t;
    bit         xEmpty;
    bit         xFull;
    logic [7:0] xDout;
    bit         xOver;
    bit         xUnder;
    bit         xTri;
  } vec_t;

  vec_t vecs[10];

  task automatic checkVal(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Queue-level FIFO rules applied once per rising edge.
  task automatic modelEdge();
    bit pe;
    bit po;
    int n;
    pe = en && push_in;
    po = en && pop_in;
    n = model.size();
    expOver  = pe && (n == 16) && !po;
    expUnder = po && (n == 0);
    if (po && n > 0) void'(model.pop_front());
    if (pe && (n < 16 || po)) model.push_back(din);
  endtask

  task automatic checkOutput(input string tag);
    logic [7:0] expDout;
    expDout = (model.size() > 0) ? model[0] : 8'h00;
    checkVal({tag, " empty"}, 8'(empty), 8'(model.size() == 0));
    checkVal({tag, " full"}, 8'(full), 8'(model.size() == 16));
    checkVal({tag, " dout"}, dout, expDout);
    checkVal({tag, " overrun"}, 8'(overrun), 8'(expOver));
    checkVal({tag, " underrun"}, 8'(underrun), 8'(expUnder));
    checkVal({tag, " thres_tri"}, 8'(thres_tri), 8'(model.size() >= int'(thres)));
  endtask

  task automatic applyStimulus(input bit e, input bit p, input bit o,
                               input logic [7:0] d, input logic [3:0] t);
    en = e;
    push_in = p;
    pop_in = o;
    din = d;
    thres = t;
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  initial begin
    vecs[0] = '{1, 1, 0, 8'hA5, 4'd1, 0, 0, 8'hA5, 0, 0, 1};
    vecs[1] = '{1, 1, 0, 8'h3C, 4'd2, 0, 0, 8'hA5, 0, 0, 1};
    vecs[2] = '{0, 1, 0, 8'h77, 4'd3, 0, 0, 8'hA5, 0, 0, 0};
    vecs[3] = '{1, 0, 1, 8'h00, 4'd1, 0, 0, 8'h3C, 0, 0, 1};
    vecs[4] = '{1, 1, 1, 8'h11, 4'd1, 0, 0, 8'h11, 0, 0, 1};
    vecs[5] = '{1, 0, 1, 8'h00, 4'd0, 1, 0, 8'h00, 0, 0, 1};
    vecs[6] = '{1, 0, 1, 8'h00, 4'd1, 1, 0, 8'h00, 0, 1, 0};
    vecs[7] = '{1, 1, 1, 8'h5A, 4'd1, 0, 0, 8'h5A, 0, 1, 1};
    vecs[8] = '{1, 0, 0, 8'h00, 4'd2, 0, 0, 8'h5A, 0, 0, 0};
    vecs[9] = '{1, 0, 1, 8'h00, 4'd1, 1, 0, 8'h00, 0, 0, 0};

    // Reset held for 5 cycles, released between edges.
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    model.delete();
    expOver = 0;
    expUnder = 0;
    #1 checkOutput("reset");
    thres = 4'd5;
    #1 checkVal("reset thres_tri at thres 5", 8'(thres_tri), 8'h00);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].e, vecs[i].p, vecs[i].o, vecs[i].d, vecs[i].t);
      checkVal($sformatf("vec%0d empty", i), 8'(empty), 8'(vecs[i].xEmpty));
      checkVal($sformatf("vec%0d full", i), 8'(full), 8'(vecs[i].xFull));
      checkVal($sformatf("vec%0d dout", i), dout, vecs[i].xDout);
      checkVal($sformatf("vec%0d overrun", i), 8'(overrun), 8'(vecs[i].xOver));
      checkVal($sformatf("vec%0d underrun", i), 8'(underrun), 8'(vecs[i].xUnder));
      checkVal($sformatf("vec%0d thres_tri", i), 8'(thres_tri), 8'(vecs[i].xTri));
    end

    for (int i = 1; i <= 20; i++) begin
      applyStimulus(1, 1, 0, 8'($urandom), 4'hA);
      checkOutput($sformatf("fill push%0d", i));
    end
    checkVal("fill full after 20 pushes", 8'(full), 8'h01);
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(1, 0, 1, 8'h00, 4'hA);
      checkOutput($sformatf("drain pop%0d", i));
    end
    checkVal("drain empty after 20 pops", 8'(empty), 8'h01);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 1, 0, 8'($urandom), 4'd0);
      checkOutput("wrap push10");
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 0, 1, 8'h00, 4'd0);
      checkOutput("wrap pop8");
    end
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1, 1, 0, 8'($urandom), 4'd14);
      checkOutput("wrap push12");
    end
    checkVal("wrap thres_tri at 14", 8'(thres_tri), 8'h01);
    for (int i = 0; i < 14; i++) begin
      applyStimulus(1, 0, 1, 8'h00, 4'd0);
      checkOutput("wrap pop14");
    end

    for (int i = 0; i < 16; i++) applyStimulus(1, 1, 0, 8'($urandom), 4'd0);
    checkOutput("full before simul");
    applyStimulus(1, 1, 1, 8'hC3, 4'd0);
    checkOutput("simul at full");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1, 0, 1, 8'h00, 4'd0);
      checkOutput("drain after simul");
    end
    applyStimulus(1, 1, 1, 8'h96, 4'd1);
    checkOutput("simul at empty");
    checkVal("simul at empty dout", dout, 8'h96);
    applyStimulus(1, 0, 1, 8'h00, 4'd1);
    checkOutput("simul empty drain");

    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 0, 8'($urandom), 4'd0);
      checkOutput("en0 push");
    end

    // Asynchronous reset lands between edges with 5 entries stored.
    for (int i = 0; i < 5; i++) applyStimulus(1, 1, 0, 8'($urandom), 4'd3);
    applyStimulus(1, 0, 0, 8'h00, 4'd3);
    #3 rst = 1'b0;
    #1;
    model.delete();
    expOver = 0;
    expUnder = 0;
    checkVal("midreset empty", 8'(empty), 8'h01);
    checkVal("midreset dout", dout, 8'h00);
    checkOutput("midreset");
    #2 rst = 1'b1;
    applyStimulus(1, 1, 0, 8'h42, 4'd1);
    checkOutput("after midreset push");

    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 9) != 0, 1'($urandom), 1'($urandom),
                    8'($urandom), 4'($urandom));
      checkOutput($sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_fifo.md
Name: uart_fifo

Overview:
- Synchronous 16-entry by 8-bit first-in first-out buffer for the UART 16550A transmit and receive paths.
- Provides empty and full status, single-cycle overrun and underrun error pulses, and a programmable fill-level trigger (thres_tri) that drives the receiver-data-available interrupt.
- Read data is first-word fall-through: dout always presents the oldest stored entry.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 16, number of entries; must be a power of two; occupancy counter is log2(DEPTH)+1 bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous active-low reset.
- en  input  1  FIFO enable; push_in and pop_in are ignored while en=0.
- push_in  input  1  write request; din is stored on the rising edge.
- pop_in  input  1  read request; the head entry is removed on the rising edge.
- din  input  WIDTH  write data.
- thres  input  4  trigger level, in entries (0..15).
- dout  output  WIDTH  head-of-queue data.
- empty  output  1  occupancy is 0.
- full  output  1  occupancy equals DEPTH.
- underrun  output  1  registered pulse; the previous cycle attempted a pop while empty.
- overrun  output  1  registered pulse; the previous cycle attempted a push while full.
- thres_tri  output  1  occupancy is at or above thres.

Behaviour:
- Reset (rst=0, asynchronous):
  - Write pointer, read pointer and count are 0.
  - Storage is cleared to 0.
  - overrun and underrun are 0.
  - Result: empty=1, full=0, dout=0, thres_tri=(thres==0).
- Reset asserted mid-operation discards all contents immediately. The first edge after rst returns high behaves as from an empty FIFO.
- Effective requests: push = en & push_in; pop = en & pop_in. Both are sampled on the rising clk edge.
- Push only:
  - If not full: mem[wptr] <= din; wptr increments modulo DEPTH; count+1.
  - If full: data is discarded, pointers and count are unchanged, overrun=1 for the next cycle.
- Pop only:
  - If not empty: rptr increments modulo DEPTH; count-1.
  - If empty: nothing changes, underrun=1 for the next cycle.
- Push and pop together:
  - Not empty and not full: both operations occur; count is unchanged.
  - Full: both occur (the write uses the slot freed by the read); count stays DEPTH; no overrun.
  - Empty: the write occurs and count becomes 1; the pop is ignored; underrun=1 for the next cycle.
- overrun and underrun are one-cycle pulses, cleared on any edge without a new error. They are not sticky; the line-status logic latches them.
- Pointers wrap from DEPTH-1 to 0 with no gap. Ordering is strictly FIFO across the wrap.
- Status outputs are combinational from registered count:
  - empty = (count==0)
  - full = (count==DEPTH)
  - thres_tri = (count >= thres), compared as zero-extended unsigned values.
  - thres may change at any time; thres_tri follows within the same cycle.
- dout:
  - Not empty: dout = mem[rptr], combinational from registered state, so it is valid the cycle after the write edge.
  - Empty: dout = 0.
- Status and dout settle one edge after the causing request; there is no additional latency.
- en=0 freezes contents, pointers and count; the error pulses clear on the next edge.

Test Plan:
- Reset: hold rst=0 for 5 cycles, then release → empty=1, full=0, dout=0, overrun=underrun=0, count 0.
- Fill past full: thres=4'hA, en=1, push 20 random bytes with pop_in=0:
  - thres_tri rises after the 10th push edge.
  - full rises after the 16th push edge.
  - overrun pulses high for each of pushes 17-20.
  - Stored contents equal the first 16 bytes.
- Drain past empty: pop 20 times with push_in=0:
  - dout sequence equals pushed bytes 1-16 in order.
  - thres_tri falls when count drops to 9.
  - empty rises after the 16th pop edge.
  - underrun pulses for pops 17-20.
- Wrap-around: push 10 bytes, pop 8, push 12 → count 14, no overrun; pop 14 → data returned in push order across the pointer wrap.
- Simultaneous push and pop:
  - At full: count stays 16, no overrun, new byte appears after the 15 older entries.
  - At empty: count becomes 1, underrun pulses, dout = din.
- Enable gating and mid-operation reset:
  - With en=0, push 3 bytes → empty stays 1.
  - With 5 entries stored, assert rst asynchronously between edges → empty=1 and dout=0 immediately.
